// File: rtl/axis_packet_merger_axilite.sv
// Two-input AXI-Stream packet merger with whole-packet arbitration (round-robin
// or fixed priority) and an AXI-lite control/status register block on aclk.
module axis_packet_merger_axilite #(
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 48
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis1_tvalid,
  output logic                     s_axis1_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis1_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis1_tkeep,
  input  logic                     s_axis1_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis1_tuser,
  input  logic                     s_axis2_tvalid,
  output logic                     s_axis2_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis2_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis2_tkeep,
  input  logic                     s_axis2_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis2_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
  input  logic                     s_axi_ctrl_awvalid,
  input  logic [6:0]               s_axi_ctrl_awaddr,
  output logic                     s_axi_ctrl_awready,
  input  logic                     s_axi_ctrl_wvalid,
  input  logic [31:0]              s_axi_ctrl_wdata,
  input  logic [3:0]               s_axi_ctrl_wstrb,
  output logic                     s_axi_ctrl_wready,
  output logic                     s_axi_ctrl_bvalid,
  output logic [1:0]               s_axi_ctrl_bresp,
  input  logic                     s_axi_ctrl_bready,
  input  logic                     s_axi_ctrl_arvalid,
  input  logic [6:0]               s_axi_ctrl_araddr,
  output logic                     s_axi_ctrl_arready,
  output logic                     s_axi_ctrl_rvalid,
  output logic [31:0]              s_axi_ctrl_rdata,
  output logic [1:0]               s_axi_ctrl_rresp,
  input  logic                     s_axi_ctrl_rready,
  output logic                     dbg_state
);

  // Handshakes: a transfer happens on a rising aclk edge where valid and ready
  // are both high; a source holds valid and its payload stable until then.

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [2:0]  ctrl;
  logic [31:0] pkt_cnt1;
  logic [31:0] pkt_cnt2;

  logic elig1, elig2, pick, in_pkt, g_valid, g_last, fire;
  logic wr_hs, rd_hs, clear_hit;
  logic [31:0] rd_mux;
  logic unused_bits;

  assign elig1   = s_axis1_tvalid & ctrl[0];
  assign elig2   = s_axis2_tvalid & ctrl[1];
  assign in_pkt  = (state == PKT);
  assign g_valid = grant ? s_axis2_tvalid : s_axis1_tvalid;
  assign g_last  = grant ? s_axis2_tlast  : s_axis1_tlast;
  assign fire    = in_pkt & g_valid & m_axis_tready & g_last;
  assign dbg_state = in_pkt;

  // Tie-break: PRIO favours port 1, RR favours the port not served last.
  always_comb begin
    pick = 1'b0;
    if (elig1 && elig2)
      pick = ctrl[2] ? 1'b0 : ~last_grant;
    else if (elig2)
      pick = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (elig1 || elig2) begin
            grant <= pick;
            state <= PKT;
          end
        end
        PKT: begin
          if (fire) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency pass-through of the granted port; nothing is buffered.
  always_comb begin
    m_axis_tvalid  = in_pkt & g_valid;
    m_axis_tdata   = grant ? s_axis2_tdata : s_axis1_tdata;
    m_axis_tkeep   = grant ? s_axis2_tkeep : s_axis1_tkeep;
    m_axis_tlast   = g_last;
    m_axis_tuser   = grant ? s_axis2_tuser : s_axis1_tuser;
    s_axis1_tready = in_pkt & ~grant & m_axis_tready;
    s_axis2_tready = in_pkt &  grant & m_axis_tready;
  end

  assign wr_hs              = s_axi_ctrl_awvalid & s_axi_ctrl_wvalid & ~s_axi_ctrl_bvalid;
  assign rd_hs              = s_axi_ctrl_arvalid & ~s_axi_ctrl_rvalid;
  assign s_axi_ctrl_awready = wr_hs;
  assign s_axi_ctrl_wready  = wr_hs;
  assign s_axi_ctrl_arready = rd_hs;
  assign s_axi_ctrl_bresp   = 2'b00;
  assign s_axi_ctrl_rresp   = 2'b00;
  assign clear_hit          = wr_hs & (s_axi_ctrl_awaddr == 7'h0C) & s_axi_ctrl_wdata[0];
  assign unused_bits        = &{1'b0, s_axi_ctrl_wstrb, s_axi_ctrl_wdata[31:3]};

  always_comb begin
    rd_mux = 32'h0;
    case (s_axi_ctrl_araddr)
      7'h00:   rd_mux = {29'h0, ctrl};
      7'h04:   rd_mux = pkt_cnt1;
      7'h08:   rd_mux = pkt_cnt2;
      7'h10:   rd_mux = {30'h0, grant, in_pkt};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ctrl              <= 3'b011;
      pkt_cnt1          <= 32'h0;
      pkt_cnt2          <= 32'h0;
      s_axi_ctrl_bvalid <= 1'b0;
      s_axi_ctrl_rvalid <= 1'b0;
      s_axi_ctrl_rdata  <= 32'h0;
    end else begin
      if (wr_hs && s_axi_ctrl_awaddr == 7'h00)
        ctrl <= s_axi_ctrl_wdata[2:0];

      if (wr_hs)
        s_axi_ctrl_bvalid <= 1'b1;
      else if (s_axi_ctrl_bready)
        s_axi_ctrl_bvalid <= 1'b0;

      // A clear beats a coincident end-of-packet increment.
      if (clear_hit) begin
        pkt_cnt1 <= 32'h0;
        pkt_cnt2 <= 32'h0;
      end else if (fire) begin
        if (grant) pkt_cnt2 <= pkt_cnt2 + 32'd1;
        else       pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end

      if (rd_hs) begin
        s_axi_ctrl_rvalid <= 1'b1;
        s_axi_ctrl_rdata  <= rd_mux;
      end else if (s_axi_ctrl_rready) begin
        s_axi_ctrl_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_merger_axilite.sv
// Bench for axis_packet_merger_axilite: register vector table, directed packet
// sequences and randomized traffic checked against a packet-level reference model.
module tb_axis_packet_merger_axilite;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int UW = 8;
  localparam int BW = UW + 1 + KW + DW;

  logic          aclk;
  logic          areset;
  logic          s_axis1_tvalid, s_axis1_tready, s_axis1_tlast;
  logic [DW-1:0] s_axis1_tdata;
  logic [KW-1:0] s_axis1_tkeep;
  logic [UW-1:0] s_axis1_tuser;
  logic          s_axis2_tvalid, s_axis2_tready, s_axis2_tlast;
  logic [DW-1:0] s_axis2_tdata;
  logic [KW-1:0] s_axis2_tkeep;
  logic [UW-1:0] s_axis2_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [6:0]    awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          dbg_state;

  axis_packet_merger_axilite #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis1_tvalid(s_axis1_tvalid), .s_axis1_tready(s_axis1_tready),
    .s_axis1_tdata(s_axis1_tdata), .s_axis1_tkeep(s_axis1_tkeep),
    .s_axis1_tlast(s_axis1_tlast), .s_axis1_tuser(s_axis1_tuser),
    .s_axis2_tvalid(s_axis2_tvalid), .s_axis2_tready(s_axis2_tready),
    .s_axis2_tdata(s_axis2_tdata), .s_axis2_tkeep(s_axis2_tkeep),
    .s_axis2_tlast(s_axis2_tlast), .s_axis2_tuser(s_axis2_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awaddr(awaddr), .s_axi_ctrl_awready(awready),
    .s_axi_ctrl_wvalid(wvalid), .s_axi_ctrl_wdata(wdata), .s_axi_ctrl_wstrb(wstrb),
    .s_axi_ctrl_wready(wready), .s_axi_ctrl_bvalid(bvalid), .s_axi_ctrl_bresp(bresp),
    .s_axi_ctrl_bready(bready), .s_axi_ctrl_arvalid(arvalid), .s_axi_ctrl_araddr(araddr),
    .s_axi_ctrl_arready(arready), .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rdata(rdata),
    .s_axi_ctrl_rresp(rresp), .s_axi_ctrl_rready(rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passed = 0;

  logic [BW-1:0] src_q1[$], src_q2[$];
  logic [BW-1:0] exp_q1[$], exp_q2[$];
  int            pkt_order[$];

  bit         model_on = 1'b0;
  int         cur = -1;
  int         last_g = 1;
  logic [2:0] ctrl_m = 3'b011;
  int         pkts[2];
  int         force_ready = -1;
  bit         rand_ready = 1'b0;
  bit         hs1, hs2;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- AXIS source driver ----------------
  initial begin
    s_axis1_tvalid = 1'b0; s_axis1_tdata = '0; s_axis1_tkeep = '0; s_axis1_tlast = 1'b0; s_axis1_tuser = '0;
    s_axis2_tvalid = 1'b0; s_axis2_tdata = '0; s_axis2_tkeep = '0; s_axis2_tlast = 1'b0; s_axis2_tuser = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      hs1 = s_axis1_tvalid && s_axis1_tready;
      hs2 = s_axis2_tvalid && s_axis2_tready;
      @(posedge aclk);
      #1;
      if (hs1 && src_q1.size() > 0) void'(src_q1.pop_front());
      if (hs2 && src_q2.size() > 0) void'(src_q2.pop_front());
      s_axis1_tvalid = (src_q1.size() > 0);
      if (src_q1.size() > 0) {s_axis1_tuser, s_axis1_tlast, s_axis1_tkeep, s_axis1_tdata} = src_q1[0];
      s_axis2_tvalid = (src_q2.size() > 0);
      if (src_q2.size() > 0) {s_axis2_tuser, s_axis2_tlast, s_axis2_tkeep, s_axis2_tdata} = src_q2[0];
      if (force_ready >= 0) m_axis_tready = (force_ready != 0);
      else if (rand_ready)  m_axis_tready = ($urandom_range(0, 1) == 1);
      else                  m_axis_tready = 1'b1;
    end
  end

  task automatic send_pkt(input int p, input int len);
    logic [BW-1:0] b;
    for (int i = 0; i < len; i++) begin
      b = {UW'($urandom), 1'(i == len - 1), KW'($urandom), DW'($urandom)};
      if (p == 0) begin src_q1.push_back(b); exp_q1.push_back(b); end
      else        begin src_q2.push_back(b); exp_q2.push_back(b); end
    end
  endtask

  // ---------------- reference model / monitor ----------------
  // Packet-level rules: an idle arbitration cycle between packets, the winner
  // chosen from the offering enabled ports, whole packets forwarded in order.
  always @(negedge aclk) begin
    logic [BW-1:0] got, want;
    bit e1, e2, sv, have;
    if (model_on) begin
      check_eq("status_in_pkt", 64'(dbg_state), 64'(cur != -1));
      if (cur < 0) begin
        check_eq("idle_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        check_eq("idle_treadys", 64'({s_axis1_tready, s_axis2_tready}), 64'(0));
        e1 = s_axis1_tvalid && ctrl_m[0];
        e2 = s_axis2_tvalid && ctrl_m[1];
        if (e1 && e2) cur = ctrl_m[2] ? 0 : (last_g == 0 ? 1 : 0);
        else if (e1)  cur = 0;
        else if (e2)  cur = 1;
      end else begin
        sv = (cur == 0) ? s_axis1_tvalid : s_axis2_tvalid;
        check_eq("pkt_m_tvalid", 64'(m_axis_tvalid), 64'(sv));
        check_eq("pkt_treadys", 64'({s_axis1_tready, s_axis2_tready}),
                 64'((cur == 0) ? {m_axis_tready, 1'b0} : {1'b0, m_axis_tready}));
        if (m_axis_tvalid && m_axis_tready) begin
          got  = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
          have = (cur == 0) ? (exp_q1.size() > 0) : (exp_q2.size() > 0);
          check_eq("beat_pending", 64'(have), 64'(1));
          want = got;
          if (have) want = (cur == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
          check_eq((cur == 0) ? "beat_p1" : "beat_p2", 64'(got), 64'(want));
          if (want[DW+KW]) begin
            pkts[cur]++;
            last_g = cur;
            pkt_order.push_back(cur);
            cur = -1;
          end
        end
      end
    end
  end

  // ---------------- AXI-lite driver tasks ----------------
  task automatic axi_write(input logic [6:0] a, input logic [31:0] d);
    int n;
    bit ok;
    @(posedge aclk); #1;
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = 4'hF;
    n = 0;
    do begin @(negedge aclk); ok = awready && wready; n++; end while (!ok && n < 50);
    check_eq("aw_handshake", 64'(ok), 64'(1));
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    if (ok && a == 7'h00) ctrl_m = d[2:0];
    if (ok && a == 7'h0C && d[0]) begin pkts[0] = 0; pkts[1] = 0; end
    n = 0;
    do begin @(negedge aclk); n++; end while (!bvalid && n < 50);
    check_eq("bvalid_seen", 64'(bvalid), 64'(1));
    check_eq("bresp", 64'(bresp), 64'(0));
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    bit ok;
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = a;
    n = 0;
    do begin @(negedge aclk); ok = arready; n++; end while (!ok && n < 50);
    check_eq("ar_handshake", 64'(ok), 64'(1));
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!rvalid && n < 50);
    check_eq("rvalid_seen", 64'(rvalid), 64'(1));
    d = rdata;
    r = rresp;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check_eq(name, 64'(d), 64'(exp));
    check_eq({name, "_rresp"}, 64'(r), 64'(0));
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while ((src_q1.size() > 0 || src_q2.size() > 0 || cur != -1) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    repeat (2) @(negedge aclk);
    check_eq(name, 64'(n < budget), 64'(1));
  endtask

  task automatic reset_model();
    cur = -1; last_g = 1; ctrl_m = 3'b011; pkts[0] = 0; pkts[1] = 0;
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    bit          do_write;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic [6:0]  raddr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[10];
  int       exp_order[4];

  initial begin
    int n;
    vecs[0] = '{1'b0, 7'h00, 32'h0,        7'h00, 32'h3};
    vecs[1] = '{1'b0, 7'h00, 32'h0,        7'h04, 32'h0};
    vecs[2] = '{1'b0, 7'h00, 32'h0,        7'h08, 32'h0};
    vecs[3] = '{1'b0, 7'h00, 32'h0,        7'h0C, 32'h0};
    vecs[4] = '{1'b0, 7'h00, 32'h0,        7'h10, 32'h0};
    vecs[5] = '{1'b0, 7'h00, 32'h0,        7'h14, 32'h0};
    vecs[6] = '{1'b1, 7'h00, 32'hFFFFFFFF, 7'h00, 32'h7};
    vecs[7] = '{1'b1, 7'h14, 32'h0000FFFF, 7'h00, 32'h7};
    vecs[8] = '{1'b1, 7'h00, 32'h5,        7'h00, 32'h5};
    vecs[9] = '{1'b1, 7'h00, 32'h3,        7'h00, 32'h3};
    exp_order = '{0, 1, 0, 1};

    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    pkts[0] = 0; pkts[1] = 0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    reset_model();
    model_on = 1'b1;

    // Register map vectors
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_write) axi_write(vecs[i].waddr, vecs[i].wdata);
      read_check($sformatf("reg_vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Round-robin with both ports busy: p1, p2, p1, p2
    @(negedge aclk);
    pkt_order.delete();
    send_pkt(0, 3); send_pkt(1, 3); send_pkt(0, 3); send_pkt(1, 3);
    wait_drained(200, "rr_drain");
    check_eq("rr_order_len", 64'(pkt_order.size()), 64'(4));
    for (int i = 0; i < 4 && i < pkt_order.size(); i++)
      check_eq($sformatf("rr_order%0d", i), 64'(pkt_order[i]), 64'(exp_order[i]));
    read_check("rr_cnt1", 7'h04, 32'd2);
    read_check("rr_cnt2", 7'h08, 32'd2);

    // Priority mode: port 2 starves while port 1 keeps offering packets
    axi_write(7'h0C, 32'h1);
    axi_write(7'h00, 32'h7);
    @(negedge aclk);
    for (int i = 0; i < 4; i++) send_pkt(0, 5);
    for (int i = 0; i < 3; i++) send_pkt(1, 3);
    n = 0;
    while (pkts[0] < 2 && n < 200) begin @(negedge aclk); n++; end
    check_eq("prio_wait", 64'(n < 200), 64'(1));
    read_check("prio_cnt2_zero", 7'h08, 32'd0);
    wait_drained(300, "prio_drain");
    read_check("prio_cnt1", 7'h04, 32'd4);
    read_check("prio_cnt2", 7'h08, 32'd3);

    // Disable port 2 while it is mid-packet: the packet must still complete
    axi_write(7'h00, 32'h3);
    @(negedge aclk);
    send_pkt(1, 8);
    n = 0;
    while (cur != 1 && n < 50) begin @(negedge aclk); n++; end
    check_eq("dis_grant_p2", 64'(cur), 64'(1));
    axi_write(7'h00, 32'h1);
    send_pkt(0, 3); send_pkt(0, 3); send_pkt(1, 4);
    n = 0;
    while ((src_q1.size() > 0 || cur != -1) && n < 200) begin @(negedge aclk); n++; end
    check_eq("dis_p1_flow", 64'(n < 200), 64'(1));
    check_eq("dis_p2_intact", 64'(exp_q2.size()), 64'(4));
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check_eq("dis_p2_tready", 64'(s_axis2_tready), 64'(0));
    end
    check_eq("dis_p2_held", 64'(src_q2.size()), 64'(4));
    axi_write(7'h00, 32'h3);
    wait_drained(200, "dis_drain");

    // Random output backpressure during a 5-beat packet
    rand_ready = 1'b1;
    @(negedge aclk);
    send_pkt(0, 5);
    wait_drained(300, "bp_drain");

    // Randomized traffic in both modes
    for (int mode = 0; mode < 2; mode++) begin
      axi_write(7'h0C, 32'h1);
      axi_write(7'h00, (mode == 1) ? 32'h7 : 32'h3);
      @(negedge aclk);
      for (int i = 0; i < 15; i++) begin
        send_pkt(0, $urandom_range(1, 5));
        send_pkt(1, $urandom_range(1, 5));
      end
      wait_drained(3000, "rand_drain");
      read_check("rand_cnt1", 7'h04, 32'(pkts[0]));
      read_check("rand_cnt2", 7'h08, 32'(pkts[1]));
    end
    rand_ready = 1'b0;
    axi_write(7'h00, 32'h3);

    // CLEAR lands on the same edge as a port 1 end-of-packet handshake
    check_eq("clr_pre_nonzero", 64'(pkts[0] > 0), 64'(1));
    force_ready = 0;
    @(negedge aclk);
    send_pkt(0, 1);
    n = 0;
    while (cur != 0 && n < 50) begin @(negedge aclk); n++; end
    check_eq("clr_grant_p1", 64'(cur), 64'(0));
    force_ready = 1;
    axi_write(7'h0C, 32'h1);
    force_ready = -1;
    wait_drained(50, "clr_drain");
    read_check("clr_cnt1", 7'h04, 32'd0);
    read_check("clr_unmapped", 7'h14, 32'd0);

    // Reset during the second beat of a port 1 packet
    @(negedge aclk);
    send_pkt(0, 5);
    n = 0;
    while (exp_q1.size() > 4 && n < 50) begin @(negedge aclk); n++; end
    check_eq("rst_first_beat", 64'(exp_q1.size()), 64'(4));
    @(posedge aclk); #1;
    areset = 1'b1;
    model_on = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_s1_tready", 64'(s_axis1_tready), 64'(0));
    check_eq("rst_dbg_state", 64'(dbg_state), 64'(0));
    src_q1.delete(); src_q2.delete(); exp_q1.delete(); exp_q2.delete();
    reset_model();
    @(posedge aclk); #1;
    areset = 1'b0;
    model_on = 1'b1;
    read_check("rst_status", 7'h10, 32'd0);
    read_check("rst_ctrl", 7'h00, 32'h3);
    read_check("rst_cnt1", 7'h04, 32'd0);
    read_check("rst_cnt2", 7'h08, 32'd0);

    // Traffic resumes after reset, port 1 first
    @(negedge aclk);
    pkt_order.delete();
    send_pkt(0, 2); send_pkt(1, 2);
    wait_drained(100, "post_rst_drain");
    check_eq("post_rst_order_len", 64'(pkt_order.size()), 64'(2));
    if (pkt_order.size() > 0) check_eq("post_rst_first", 64'(pkt_order[0]), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_packet_merger_axilite.md
AXIS_PACKET_MERGER_AXILITE -- requirements
Module: axis_packet_merger_axilite

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 512, AXIS data width in bits.
REQ-002 SHALL have parameter TUSER_WIDTH, default 48, AXIS tuser width in bits.
REQ-003 SHALL have port aclk  input  1  the only clock; all logic, including the control registers, is on aclk.
REQ-004 SHALL have port areset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports s_axis1_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/TDATA_WIDTH/TDATA_WIDTH/8/1/TUSER_WIDTH  input port 1.
REQ-006 SHALL have ports s_axis2_* with the same set and widths as REQ-005  input port 2.
REQ-007 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  same widths  merged output.
REQ-008 SHALL have AXI-lite slave ports s_axi_ctrl_awvalid/awaddr[6:0]/awready, wvalid/wdata[31:0]/wstrb[3:0]/wready, bvalid/bresp[1:0]/bready, arvalid/araddr[6:0]/arready, rvalid/rdata[31:0]/rresp[1:0]/rready; all are on aclk; wstrb is ignored.

Function
REQ-009 SHALL use a grant FSM with states IDLE and PKT, plus a 1-bit grant register (0 = port 1, 1 = port 2).
REQ-010 In IDLE: m_axis_tvalid = 0 and both s_axis*_tready = 0.
REQ-011 In IDLE, a port is eligible when its tvalid = 1 and its enable bit is 1; if any port is eligible, the FSM SHALL load grant and enter PKT on the next cycle.
REQ-012 The one-cycle IDLE bubble between packets is required, not optional.
REQ-013 Mode RR (CTRL.mode = 0): if both ports are eligible, grant goes to the port not granted last; last_grant resets to port 2, so port 1 wins first.
REQ-014 Mode PRIO (CTRL.mode = 1): port 1 always wins a tie.
REQ-015 If only one port is eligible, that port is granted in either mode.
REQ-016 In PKT: m_axis_t{valid,data,keep,last,user} SHALL equal the granted input combinationally; the granted tready = m_axis_tready; the other port's tready = 0. Latency is zero.
REQ-017 Packets are atomic: PKT returns to IDLE only on a cycle with granted tvalid & m_axis_tready & tlast; last_grant is updated at that point.
REQ-018 CTRL changes take effect only at the next IDLE arbitration; disabling a port mid-packet SHALL NOT truncate that packet.
REQ-019 The block SHALL NOT buffer any beats; a stalled output stalls only the granted input.
REQ-020 PKT_CNTn SHALL increment by 1 on each tlast handshake forwarded from port n; the counter is 32 bits and wraps 0xFFFFFFFF -> 0.
REQ-021 Register map: 0x00 CTRL RW; 0x04 PKT_CNT1 RO; 0x08 PKT_CNT2 RO; 0x0C CLEAR WO (reads 0); 0x10 STATUS RO; all other addresses read 0, ignore writes, and respond OKAY.
REQ-022 CTRL fields: bit0 en1, bit1 en2, bit2 mode; bits 31:3 read 0.
REQ-023 CLEAR: writing bit0 = 1 SHALL zero both counters on the next cycle; if a clear and an increment coincide, the clear wins (result 0).
REQ-024 STATUS fields: bit0 = 1 in PKT; bit1 = grant register.
REQ-025 Write channel: awready = wready = 1 for one cycle only when awvalid & wvalid & !bvalid; the register updates in that cycle; bvalid rises the next cycle and holds until bready; bresp = 0.
REQ-026 Read channel: arready = 1 for one cycle when arvalid & !rvalid; rdata is registered with rvalid the next cycle and held until rready; rresp = 0.
REQ-027 Only one outstanding transaction per channel is allowed; read and write are independent and may complete in the same cycle.

Reset
REQ-028 On areset = 1 at a clock edge: FSM = IDLE, grant = 0, last_grant = 1, CTRL = 0x3 (both ports enabled, RR), counters = 0, awready = wready = arready = bvalid = rvalid = 0; all AXIS outputs valid/ready = 0 the following cycle.
REQ-029 Reset mid-packet SHALL abandon the packet; no recovery of partial packets is required.

Verification
REQ-030 Both ports send 3-beat packets continuously, RR, tready = 1 -> output packet order is p1, p2, p1, p2; one idle cycle between packets; PKT_CNT1 = PKT_CNT2 = 2 after 4 packets.
REQ-031 PRIO mode (write CTRL = 0x7), both ports always valid -> only port 1 is forwarded; port2 tready stays 0; PKT_CNT2 = 0.
REQ-032 Port 2 mid-packet, write CTRL = 0x1 -> the port 2 packet completes intact; afterwards s_axis2_tready = 0 and port 1 packets flow.
REQ-033 m_axis_tready toggled randomly during a 5-beat packet -> all beats are in order and unduplicated; granted tready mirrors m_axis_tready exactly.
REQ-034 Preload PKT_CNT1 near wrap, then write CLEAR = 1 in the same cycle as a port 1 tlast handshake -> reading 0x04 returns 0; reading 0x14 returns 0 with rresp = 0.
REQ-035 Assert areset during the 2nd beat of a port 1 packet -> next cycle m_axis_tvalid = 0, STATUS = 0, CTRL = 0x3, counters = 0.
